// File: rtl/line_buf_ctrl.sv
// line_buf_ctrl: address/enable sequencer for the two-line 3x3 window buffer.
// Tracks column/row position from pix_vs/pix_hs/pix_de timing, drives the
// line RAM read/write ports, and flags complete 3x3 windows.
// Optional build macro: LINE_BUF_CTRL_WIDTH_CHECK_EN enables the per-frame
// line width consistency check (width_err); otherwise width_err is tied low.
module line_buf_ctrl #(
  parameter int ADDR_W  = 10,
  parameter int ROW_W   = 11,
  parameter int RAM_LAT = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              pix_vs,
  input  logic              pix_hs,
  input  logic              pix_de,
  output logic [ADDR_W-1:0] rd_addr,
  output logic [ADDR_W-1:0] wr_addr,
  output logic              wr_en,
  output logic              win_valid,
  output logic [ADDR_W-1:0] win_col,
  output logic [ROW_W-1:0]  win_row,
  output logic [ADDR_W:0]   line_width,
  output logic              ovf_err,
  output logic              width_err,
  output logic [1:0]        state
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FILL0  = 2'd1,
    FILL1  = 2'd2,
    STREAM = 2'd3
  } state_t;

  localparam int                LAST     = RAM_LAT - 1;
  localparam logic [ADDR_W:0]   CNT_FULL = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W-1:0] COL_MAX  = '1;
  localparam logic [ROW_W-1:0]  ROW_MAX  = '1;

  state_t            cur_st, nxt_st;
  logic              vs_q, hs_q;
  logic [ADDR_W-1:0] col;
  logic [ADDR_W:0]   cnt;
  logic [ROW_W-1:0]  row;
  logic              vs_rise, vs_fall, accept, over, line_ok, advance;

  logic              d_acc  [RAM_LAT];
  logic              d_ovf  [RAM_LAT];
  logic              d_strm [RAM_LAT];
  logic [ADDR_W-1:0] d_col  [RAM_LAT];
  logic [ROW_W-1:0]  d_row  [RAM_LAT];
  logic [ADDR_W-1:0] win_col_q;
  logic [ROW_W-1:0]  win_row_q;

  // vs_q resets high so a frame already running at reset release is not
  // mistaken for a new frame start; pix_vs must drop first.
  assign vs_rise = pix_vs & ~vs_q;
  assign vs_fall = ~pix_vs & vs_q;
  assign accept  = pix_hs & pix_de & (cur_st != IDLE);
  assign over    = accept & (cnt == CNT_FULL);
  assign line_ok = hs_q & ~pix_hs & (cnt != '0) & (cur_st != IDLE) & ~vs_rise;
  assign advance = line_ok & ~vs_fall;

  assign rd_addr = col;
  assign wr_addr = d_col[LAST];
  assign state   = cur_st;

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) cur_st <= IDLE;
    else     cur_st <= nxt_st;
  end

  // Next state and write/window outputs from the tail of the delay line
  always_comb begin
    nxt_st    = cur_st;
    wr_en     = 1'b0;
    win_valid = 1'b0;
    win_col   = win_col_q;
    win_row   = win_row_q;
    if (vs_fall)      nxt_st = IDLE;
    else if (vs_rise) nxt_st = FILL0;
    else if (advance) begin
      case (cur_st)
        FILL0:   nxt_st = FILL1;
        FILL1:   nxt_st = STREAM;
        default: nxt_st = cur_st;
      endcase
    end
    // Pixels accepted before STREAM can surface after the state moves on,
    // so the window also needs the state captured at accept time.
    wr_en     = d_acc[LAST] & ~d_ovf[LAST] & (cur_st != IDLE);
    win_valid = wr_en & d_strm[LAST] & (cur_st == STREAM) &
                (d_col[LAST] >= ADDR_W'(2));
    if (win_valid) begin
      win_col = d_col[LAST];
      win_row = d_row[LAST];
    end
  end

  // Edge detect registers and column / pixel counters
  always_ff @(posedge clk) begin
    if (rst) begin
      vs_q <= 1'b1;
      hs_q <= 1'b0;
      col  <= '0;
      cnt  <= '0;
    end else begin
      vs_q <= pix_vs;
      hs_q <= pix_hs;
      if (!pix_hs) begin
        col <= '0;
        cnt <= '0;
      end else if (accept) begin
        if (cnt != CNT_FULL) cnt <= cnt + (ADDR_W+1)'(1);
        if (col != COL_MAX)  col <= col + ADDR_W'(1);
      end
    end
  end

  // Row count, measured line width and sticky overflow flag
  always_ff @(posedge clk) begin
    if (rst) begin
      row        <= '0;
      line_width <= '0;
      ovf_err    <= 1'b0;
    end else begin
      if (vs_rise)                         row <= '0;
      else if (advance && row != ROW_MAX)  row <= row + ROW_W'(1);
      if (line_ok) line_width <= cnt;
      if (vs_rise)   ovf_err <= 1'b0;
      else if (over) ovf_err <= 1'b1;
    end
  end

  // Write-path delay line: accept strobe, overflow, stream flag, col, row
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < RAM_LAT; i++) begin
        d_acc[i]  <= 1'b0;
        d_ovf[i]  <= 1'b0;
        d_strm[i] <= 1'b0;
        d_col[i]  <= '0;
        d_row[i]  <= '0;
      end
    end else begin
      d_acc[0]  <= accept;
      d_ovf[0]  <= over;
      d_strm[0] <= (cur_st == STREAM);
      d_col[0]  <= col;
      d_row[0]  <= row;
      for (int unsigned i = 1; i < RAM_LAT; i++) begin
        d_acc[i]  <= d_acc[i-1];
        d_ovf[i]  <= d_ovf[i-1];
        d_strm[i] <= d_strm[i-1];
        d_col[i]  <= d_col[i-1];
        d_row[i]  <= d_row[i-1];
      end
    end
  end

  // Hold the last window position between window strobes
  always_ff @(posedge clk) begin
    if (rst) begin
      win_col_q <= '0;
      win_row_q <= '0;
    end else if (win_valid) begin
      win_col_q <= d_col[LAST];
      win_row_q <= d_row[LAST];
    end
  end

`ifdef LINE_BUF_CTRL_WIDTH_CHECK_EN
  logic [ADDR_W:0] ref_w;
  logic            ref_ok;
  logic            werr_q;

  // First completed line of the frame is the reference width
  always_ff @(posedge clk) begin
    if (rst) begin
      ref_w  <= '0;
      ref_ok <= 1'b0;
      werr_q <= 1'b0;
    end else if (vs_rise) begin
      ref_ok <= 1'b0;
      werr_q <= 1'b0;
    end else if (line_ok) begin
      if (!ref_ok) begin
        ref_w  <= cnt;
        ref_ok <= 1'b1;
      end else if (cnt != ref_w) begin
        werr_q <= 1'b1;
      end
    end
  end

  assign width_err = werr_q;
`else
  assign width_err = 1'b0;
`endif

endmodule

// File: tb/tb_line_buf_ctrl.sv
// Bench for line_buf_ctrl: two instances (ADDR_W=10 and ADDR_W=3) share one
// stimulus stream; a behavioural frame/line/pixel model predicts every output.
module tb_line_buf_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic pix_vs = 1'b0, pix_hs = 1'b0, pix_de = 1'b0;

  always #5 clk = ~clk;

  logic [9:0]  rd_addr_a, wr_addr_a, win_col_a;
  logic [10:0] win_row_a, win_row_b, line_width_a;
  logic        wr_en_a, win_valid_a, ovf_err_a, width_err_a;
  logic [1:0]  state_a, state_b;
  logic [2:0]  rd_addr_b, wr_addr_b, win_col_b;
  logic [3:0]  line_width_b;
  logic        wr_en_b, win_valid_b, ovf_err_b, width_err_b;

  line_buf_ctrl #(.ADDR_W(10), .ROW_W(11), .RAM_LAT(2)) u_dut_a (
    .clk(clk), .rst(rst), .pix_vs(pix_vs), .pix_hs(pix_hs), .pix_de(pix_de),
    .rd_addr(rd_addr_a), .wr_addr(wr_addr_a), .wr_en(wr_en_a),
    .win_valid(win_valid_a), .win_col(win_col_a), .win_row(win_row_a),
    .line_width(line_width_a), .ovf_err(ovf_err_a), .width_err(width_err_a),
    .state(state_a));

  line_buf_ctrl #(.ADDR_W(3), .ROW_W(11), .RAM_LAT(2)) u_dut_b (
    .clk(clk), .rst(rst), .pix_vs(pix_vs), .pix_hs(pix_hs), .pix_de(pix_de),
    .rd_addr(rd_addr_b), .wr_addr(wr_addr_b), .wr_en(wr_en_b),
    .win_valid(win_valid_b), .win_col(win_col_b), .win_row(win_row_b),
    .line_width(line_width_b), .ovf_err(ovf_err_b), .width_err(width_err_b),
    .state(state_b));

`ifdef LINE_BUF_CTRL_WIDTH_CHECK_EN
  localparam bit WCHK = 1'b1;
`else
  localparam bit WCHK = 1'b0;
`endif
  localparam int ROWMAX = 2047;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  bit started = 1'b0;

  task automatic chk(input string nm, input int m, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s[inst%0d] cyc %0d: got %0d, expected %0d", nm, m, cyc, act, exp);
    end
  endtask

  function automatic int imin(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  // ---------------- behavioural model ----------------
  typedef struct {
    int due;
    int inst;
    bit wr;
    bit win;
    int col;
    int row;
  } ev_t;
  ev_t evq[$];

  bit m_active[2], m_pvs[2], m_phs[2], m_ovf[2], m_werr[2];
  int m_lines[2], m_npix[2], m_width[2], m_ref[2];
  int m_hp0[2], m_hp1[2], m_hcol[2], m_hrow[2];
  int e_st[2], e_rd[2], e_wa[2], e_we[2], e_wv[2], e_wc[2], e_wr[2];
  int e_lw[2], e_ovf[2], e_werr[2];
  int mdl_win[2], mdl_wr[2], fw_col[2], fw_row[2];

  task automatic model_step(input int m);
    int  aw, full, maxc, colnow, rdnow;
    bit  rise, fall, acc, over, le;
    ev_t e;
    aw   = (m == 0) ? 10 : 3;
    full = 1 << aw;
    maxc = full - 1;
    if (rst) begin
      m_active[m] = 0; m_pvs[m] = 1; m_phs[m] = 0; m_ovf[m] = 0; m_werr[m] = 0;
      m_lines[m] = 0; m_npix[m] = 0; m_width[m] = 0; m_ref[m] = -1;
      m_hp0[m] = 0; m_hp1[m] = 0; m_hcol[m] = 0; m_hrow[m] = 0;
      evq.delete();
      e_st[m] = 0; e_rd[m] = 0; e_wa[m] = 0; e_we[m] = 0; e_wv[m] = 0;
      e_wc[m] = 0; e_wr[m] = 0; e_lw[m] = 0; e_ovf[m] = 0; e_werr[m] = 0;
    end else begin
      rise = pix_vs && !m_pvs[m];
      fall = !pix_vs && m_pvs[m];
      acc  = m_active[m] && pix_hs && pix_de;
      if (acc) begin
        over   = (m_npix[m] == full);
        colnow = imin(m_npix[m], maxc);
        e.due  = cyc + 1;
        e.inst = m;
        e.wr   = !over;
        e.win  = !over && (m_lines[m] >= 2) && (colnow >= 2);
        e.col  = colnow;
        e.row  = m_lines[m];
        evq.push_back(e);
        if (over) m_ovf[m] = 1;
        else      m_npix[m]++;
      end
      le = m_active[m] && m_phs[m] && !pix_hs && (m_npix[m] > 0) && !rise;
      if (le) begin
        m_width[m] = m_npix[m];
        if (m_ref[m] < 0)               m_ref[m] = m_npix[m];
        else if (m_npix[m] != m_ref[m]) m_werr[m] = 1;
        if (!fall) m_lines[m] = imin(m_lines[m] + 1, ROWMAX);
      end
      if (!pix_hs) m_npix[m] = 0;
      if (rise) begin
        m_active[m] = 1; m_lines[m] = 0; m_ovf[m] = 0; m_werr[m] = 0; m_ref[m] = -1;
      end else if (fall) begin
        m_active[m] = 0;
      end
      m_pvs[m] = pix_vs;
      m_phs[m] = pix_hs;

      rdnow   = pix_hs ? imin(m_npix[m], maxc) : 0;
      e_rd[m] = rdnow;
      e_wa[m] = m_hp1[m];
      m_hp1[m] = m_hp0[m];
      m_hp0[m] = rdnow;
      e_st[m] = !m_active[m] ? 0 : ((m_lines[m] >= 2) ? 3 : m_lines[m] + 1);
      e_we[m] = 0;
      e_wv[m] = 0;
      foreach (evq[i]) begin
        if (evq[i].inst == m && evq[i].due == cyc) begin
          e_we[m] = (evq[i].wr && m_active[m]) ? 1 : 0;
          e_wv[m] = (evq[i].win && m_active[m] && m_lines[m] >= 2) ? 1 : 0;
          if (e_wv[m] != 0) begin
            m_hcol[m] = evq[i].col;
            m_hrow[m] = evq[i].row;
            if (fw_col[m] < 0) begin
              fw_col[m] = evq[i].col;
              fw_row[m] = evq[i].row;
            end
          end
        end
      end
      mdl_wr[m]  += e_we[m];
      mdl_win[m] += e_wv[m];
      e_wc[m]   = m_hcol[m];
      e_wr[m]   = m_hrow[m];
      e_lw[m]   = m_width[m];
      e_ovf[m]  = m_ovf[m];
      e_werr[m] = WCHK ? m_werr[m] : 0;
    end
  endtask

  initial begin
    fw_col = '{-1, -1};
    fw_row = '{-1, -1};
    forever begin
      @(posedge clk);
      cyc++;
      while (evq.size() > 0 && evq[0].due < cyc) void'(evq.pop_front());
      model_step(0);
      model_step(1);
      started = 1'b1;
    end
  end

  // ---------------- per-cycle compare ----------------
  task automatic cmp(input int m, input int st, input int ra, input int wa, input int we,
                     input int wv, input int wc, input int wr, input int lw,
                     input int ov, input int werr);
    chk("state", m, st, e_st[m]);
    chk("rd_addr", m, ra, e_rd[m]);
    chk("wr_addr", m, wa, e_wa[m]);
    chk("wr_en", m, we, e_we[m]);
    chk("win_valid", m, wv, e_wv[m]);
    chk("win_col", m, wc, e_wc[m]);
    chk("win_row", m, wr, e_wr[m]);
    chk("line_width", m, lw, e_lw[m]);
    chk("ovf_err", m, ov, e_ovf[m]);
    chk("width_err", m, werr, e_werr[m]);
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (started) begin
        cmp(0, int'(state_a), int'(rd_addr_a), int'(wr_addr_a), int'(wr_en_a),
            int'(win_valid_a), int'(win_col_a), int'(win_row_a), int'(line_width_a),
            int'(ovf_err_a), int'(width_err_a));
        cmp(1, int'(state_b), int'(rd_addr_b), int'(wr_addr_b), int'(wr_en_b),
            int'(win_valid_b), int'(win_col_b), int'(win_row_b), int'(line_width_b),
            int'(ovf_err_b), int'(width_err_b));
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic do_line(input int npx, input int gap, input bit rnd, input bit drop_vs);
    pix_hs = 1'b1;
    if (npx == 0) @(negedge clk);
    for (int p = 0; p < npx; p++) begin
      pix_de = 1'b1;
      @(negedge clk);
      pix_de = 1'b0;
      repeat (rnd ? int'($urandom_range(0, 2)) : gap) @(negedge clk);
    end
    pix_hs = 1'b0;
    pix_de = 1'($urandom_range(0, 1));
    if (drop_vs) pix_vs = 1'b0;
    repeat (3) begin
      @(negedge clk);
      pix_de = 1'($urandom_range(0, 1));
    end
  endtask

  task automatic frame_start();
    pix_vs = 1'b0;
    @(negedge clk);
    pix_vs = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic frame_end();
    pix_vs = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  int w0, r0, r1;

  initial begin
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_state", 0, int'(state_a), 0);
    chk("rst_wr_en", 0, int'(wr_en_a), 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // 4 lines x 8 pixels, continuous
    frame_start();
    chk("fill0_state", 0, int'(state_a), 1);
    w0 = mdl_win[0];
    fw_col[0] = -1;
    do_line(8, 0, 0, 0);
    chk("l1_state", 0, int'(state_a), 2);
    chk("l1_width", 0, int'(line_width_a), 8);
    do_line(8, 0, 0, 0);
    chk("l2_state", 0, int'(state_a), 3);
    do_line(8, 0, 0, 0);
    do_line(8, 0, 0, 0);
    chk("l4_width", 0, int'(line_width_a), 8);
    chk("pin_win_pulses", 0, mdl_win[0] - w0, 12);
    chk("pin_first_col", 0, fw_col[0], 2);
    chk("pin_first_row", 0, fw_row[0], 2);
    frame_end();

    // gapped 5-pixel line
    frame_start();
    r0 = mdl_wr[0];
    do_line(5, 2, 0, 0);
    chk("pin_gap_wr", 0, mdl_wr[0] - r0, 5);
    chk("gap_width", 0, int'(line_width_a), 5);
    frame_end();

    // 10-pixel line: overflows the ADDR_W=3 instance only
    frame_start();
    r0 = mdl_wr[0];
    r1 = mdl_wr[1];
    do_line(10, 0, 0, 0);
    chk("ovf_b_set", 1, int'(ovf_err_b), 1);
    chk("ovf_a_clear", 0, int'(ovf_err_a), 0);
    chk("pin_ovf_wr_b", 1, mdl_wr[1] - r1, 8);
    chk("pin_ovf_wr_a", 0, mdl_wr[0] - r0, 10);
    chk("ovf_width_b", 1, int'(line_width_b), 8);
    frame_end();
    chk("ovf_b_sticky", 1, int'(ovf_err_b), 1);
    frame_start();
    chk("ovf_b_cleared", 1, int'(ovf_err_b), 0);

    // width check: 8, 8, 7
    do_line(8, 0, 0, 0);
    do_line(8, 0, 0, 0);
    chk("werr_before", 0, int'(width_err_a), 0);
    do_line(7, 0, 0, 0);
    chk("werr_after", 0, int'(width_err_a), int'(WCHK));
    chk("w7_width", 0, int'(line_width_a), 7);

    // pix_vs falls together with pix_hs in STREAM
    r0 = mdl_wr[0];
    do_line(6, 0, 0, 1);
    chk("vsfall_state", 0, int'(state_a), 0);
    chk("pin_vsfall_rows", 0, m_lines[0], 3);
    chk("pin_vsfall_wr", 0, mdl_wr[0] - r0, 5);
    repeat (2) @(negedge clk);

    // reset mid-stream
    frame_start();
    repeat (3) do_line(8, 0, 0, 0);
    pix_hs = 1'b1;
    repeat (3) begin
      pix_de = 1'b1;
      @(negedge clk);
      pix_de = 1'b0;
    end
    rst = 1'b1;
    repeat (3) begin
      @(negedge clk);
      pix_de = ~pix_de;
    end
    rst = 1'b0;
    chk("mid_rst_state", 0, int'(state_a), 0);
    chk("mid_rst_width", 0, int'(line_width_a), 0);
    chk("mid_rst_rd", 0, int'(rd_addr_a), 0);
    repeat (4) begin
      pix_de = 1'b1;
      @(negedge clk);
      pix_de = 1'b0;
      @(negedge clk);
    end
    chk("post_rst_rd", 0, int'(rd_addr_a), 0);
    chk("post_rst_state", 0, int'(state_a), 0);
    pix_hs = 1'b0;
    repeat (2) @(negedge clk);
    do_line(8, 0, 0, 0);
    chk("ignored_width", 0, int'(line_width_a), 0);
    frame_end();
    frame_start();
    do_line(8, 0, 0, 0);
    chk("resume_width", 0, int'(line_width_a), 8);
    chk("resume_state", 0, int'(state_a), 2);
    frame_end();

    // randomized frames
    for (int f = 0; f < 8; f++) begin
      int nl;
      frame_start();
      nl = int'($urandom_range(0, 6));
      for (int l = 0; l < nl; l++)
        do_line(int'($urandom_range(0, 12)), 0, 1'($urandom_range(0, 1)), 0);
      frame_end();
    end

    repeat (3) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
